// File: rtl/core_issue_ctrl.sv
// core_issue_ctrl: in-order 2-wide issue decision for the backend.
// Consumes the frontend's decoded window, tracks long-latency writers in a
// register busy-scoreboard, and registers the issued group for execute.
module core_issue_ctrl #(
    parameter int REG_NUM  = 32,
    parameter int REG_W    = 5,
    parameter int WB_PORTS = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush_i,
    input  logic [1:0]                         inst_valid_i,
    input  logic [1:0][1:0][REG_W-1:0]         r_reg_i,
    input  logic [1:0][REG_W-1:0]              w_reg_i,
    input  logic [1:0]                         long_lat_i,
    input  logic [1:0]                         single_i,
    input  logic                               ex_ready_i,
    input  logic [WB_PORTS-1:0]                wb_valid_i,
    input  logic [WB_PORTS-1:0][REG_W-1:0]     wb_reg_i,
    output logic [1:0]                         issue_o,
    output logic [1:0]                         ex_valid_o,
    output logic [REG_NUM-1:0]                 sb_busy_o
);

    logic [REG_NUM-1:0] sb_busy;
    logic [REG_NUM-1:0] sb_next;
    logic [REG_NUM-1:0] wb_hit;
    logic [REG_NUM-1:0] eff_busy;
    logic [1:0]         ex_valid;
    logic [1:0]         hz;
    logic               pair_dep;

    // A nonzero register is busy unless a writeback for it arrives this cycle.
    function automatic logic reg_busy(input logic [REG_NUM-1:0] busy_vec,
                                      input logic [REG_W-1:0]   idx);
        return (idx != '0) && busy_vec[idx];
    endfunction

    // Decode this cycle's writebacks into a per-register hit vector.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wb_hit = '0;
        for (int k = 0; k < WB_PORTS; k++) begin
            if (wb_valid_i[k]) wb_hit[wb_reg_i[k]] = 1'b1;
        end
    end

    assign eff_busy = sb_busy & ~wb_hit;

    // Per-slot RAW/WAW hazards against the scoreboard, plus the intra-pair dependency.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hz[p] = reg_busy(eff_busy, r_reg_i[p][0])
                  | reg_busy(eff_busy, r_reg_i[p][1])
                  | reg_busy(eff_busy, w_reg_i[p]);
        end
        pair_dep = (w_reg_i[0] != '0) &&
                   ((w_reg_i[0] == r_reg_i[1][0]) ||
                    (w_reg_i[0] == r_reg_i[1][1]) ||
                    (w_reg_i[0] == w_reg_i[1]));
    end

    // Issue acknowledge: slot1 can only go together with slot0.
    always_comb begin
        issue_o[0] = rst_n & inst_valid_i[0] & ex_ready_i & ~flush_i & ~hz[0];
        issue_o[1] = issue_o[0] & inst_valid_i[1] & ~single_i[0] & ~single_i[1]
                   & ~hz[1] & ~pair_dep;
    end

    // Next scoreboard: writebacks clear first, then issuing long-latency writers set.
    always_comb begin
        sb_next = sb_busy & ~wb_hit;
        for (int p = 0; p < 2; p++) begin
            if (issue_o[p] && long_lat_i[p] && (w_reg_i[p] != '0))
                sb_next[w_reg_i[p]] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // Scoreboard and execute-stage issue register; flush leaves the scoreboard intact.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            sb_busy  <= '0;
            ex_valid <= '0;
        end else begin
            sb_busy <= sb_next;
            if (flush_i)         ex_valid <= 2'b00;
            else if (ex_ready_i) ex_valid <= issue_o;
        end
    end

    assign ex_valid_o = ex_valid;
    assign sb_busy_o  = sb_busy;

    // The frontend window is packed from slot0; a lone slot1 is illegal.
    a_no_lone_slot1: assert property (@(posedge clk) disable iff (!rst_n)
                                      inst_valid_i != 2'b10);
    // Issue stays in order.
    a_no_issue_10: assert property (@(posedge clk) disable iff (!rst_n)
                                    issue_o != 2'b10);

endmodule

// File: tb/tb_core_issue_ctrl.sv
// tb_core_issue_ctrl: directed bench for core_issue_ctrl.
// A vector table covers the combinational issue rules; hand sequences cover
// scoreboard, flush, stall and reset behaviour across cycles.
module tb_core_issue_ctrl;

    localparam int REG_NUM  = 32;
    localparam int REG_W    = 5;
    localparam int WB_PORTS = 2;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic                           flush;
    logic [1:0]                     inst_valid;
    logic [1:0][1:0][REG_W-1:0]     r_reg;
    logic [1:0][REG_W-1:0]          w_reg;
    logic [1:0]                     long_lat;
    logic [1:0]                     single;
    logic                           ex_ready;
    logic [WB_PORTS-1:0]            wb_valid;
    logic [WB_PORTS-1:0][REG_W-1:0] wb_reg;
    logic [1:0]                     issue;
    logic [1:0]                     ex_valid;
    logic [REG_NUM-1:0]             sb_busy;

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] exp_ex   = 2'b00;

    core_issue_ctrl #(.REG_NUM(REG_NUM), .REG_W(REG_W), .WB_PORTS(WB_PORTS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .inst_valid_i (inst_valid),
        .r_reg_i      (r_reg),
        .w_reg_i      (w_reg),
        .long_lat_i   (long_lat),
        .single_i     (single),
        .ex_ready_i   (ex_ready),
        .wb_valid_i   (wb_valid),
        .wb_reg_i     (wb_reg),
        .issue_o      (issue),
        .ex_valid_o   (ex_valid),
        .sb_busy_o    (sb_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] valid;
        logic [4:0] r00, r01, w0, r10, r11, w1;
        logic [1:0] ll;
        logic [1:0] sgl;
        logic       ready;
        logic       flsh;
        logic [1:0] exp_issue;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush      = 1'b0;
        inst_valid = 2'b00;
        r_reg      = '0;
        w_reg      = '0;
        long_lat   = 2'b00;
        single     = 2'b00;
        ex_ready   = 1'b1;
        wb_valid   = '0;
        wb_reg     = '0;
    endtask

    task automatic indep_pair();
        inst_valid  = 2'b11;
        r_reg[0][0] = 5'd1; r_reg[0][1] = 5'd2; w_reg[0] = 5'd3;
        r_reg[1][0] = 5'd4; r_reg[1][1] = 5'd5; w_reg[1] = 5'd6;
    endtask

    // Inputs are already driven just after a posedge: check issue mid-cycle,
    // then step through the edge and check the registered state.
    task automatic cycle(input string name, input logic [1:0] exp_issue,
                         input logic [31:0] exp_sb);
        @(negedge clk);
        check({name, ".issue"}, 64'(issue), 64'(exp_issue));
        if (!rst_n || flush) exp_ex = 2'b00;
        else if (ex_ready)   exp_ex = exp_issue;
        @(posedge clk); #1;
        check({name, ".ex_valid"}, 64'(ex_valid), 64'(exp_ex));
        check({name, ".sb_busy"}, 64'(sb_busy), 64'(exp_sb));
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{"indep",      2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11};
        tbl[1]  = '{"pair_raw0",  2'b11, 5'd1, 5'd2, 5'd3, 5'd3, 5'd5, 5'd6, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01};
        tbl[2]  = '{"pair_raw1",  2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 5'd3, 5'd6, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01};
        tbl[3]  = '{"pair_waw",   2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd3, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01};
        tbl[4]  = '{"w0_zero",    2'b11, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd6, 2'b00, 2'b00, 1'b1, 1'b0, 2'b11};
        tbl[5]  = '{"single1",    2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 2'b00, 2'b10, 1'b1, 1'b0, 2'b01};
        tbl[6]  = '{"single0",    2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 2'b00, 2'b01, 1'b1, 1'b0, 2'b01};
        tbl[7]  = '{"not_ready",  2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00};
        tbl[8]  = '{"flush",      2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00};
        tbl[9]  = '{"slot0_only", 2'b01, 5'd1, 5'd2, 5'd3, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01};
        tbl[10] = '{"empty",      2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00};

        // Reset: issue held low even with a valid, hazard-free window.
        idle();
        rst_n = 1'b0;
        indep_pair();
        cycle("reset0", 2'b00, 32'h0);
        cycle("reset1", 2'b00, 32'h0);
        rst_n = 1'b1;

        // Issue-rule table against an empty scoreboard.
        for (int i = 0; i < 11; i++) begin
            idle();
            inst_valid  = tbl[i].valid;
            r_reg[0][0] = tbl[i].r00; r_reg[0][1] = tbl[i].r01; w_reg[0] = tbl[i].w0;
            r_reg[1][0] = tbl[i].r10; r_reg[1][1] = tbl[i].r11; w_reg[1] = tbl[i].w1;
            long_lat    = tbl[i].ll;
            single      = tbl[i].sgl;
            ex_ready    = tbl[i].ready;
            flush       = tbl[i].flsh;
            cycle(tbl[i].name, tbl[i].exp_issue, 32'h0);
        end

        // Pair dependency then window shift: the held slot1 issues next cycle.
        idle(); inst_valid = 2'b11; r_reg[0][0] = 5'd1; w_reg[0] = 5'd3; r_reg[1][0] = 5'd3; w_reg[1] = 5'd4;
        cycle("dep_first", 2'b01, 32'h0);
        idle(); inst_valid = 2'b01; r_reg[0][0] = 5'd3; w_reg[0] = 5'd4;
        cycle("dep_shift", 2'b01, 32'h0);

        // Load to r7, then stall readers/writers of r7 until its writeback.
        idle(); inst_valid = 2'b01; r_reg[0][0] = 5'd1; w_reg[0] = 5'd7; long_lat = 2'b01;
        cycle("load_r7", 2'b01, 32'h0000_0080);
        idle(); inst_valid = 2'b11; r_reg[0][0] = 5'd7; w_reg[0] = 5'd8; r_reg[1][0] = 5'd2; w_reg[1] = 5'd9;
        cycle("raw_stall", 2'b00, 32'h0000_0080);
        idle(); inst_valid = 2'b01; w_reg[0] = 5'd7;
        cycle("waw_stall", 2'b00, 32'h0000_0080);
        idle(); inst_valid = 2'b11; r_reg[0][0] = 5'd1; w_reg[0] = 5'd2; r_reg[1][1] = 5'd7; w_reg[1] = 5'd3;
        cycle("slot1_raw", 2'b01, 32'h0000_0080);
        idle(); inst_valid = 2'b01; r_reg[0][0] = 5'd7; w_reg[0] = 5'd8; wb_valid = 2'b01; wb_reg[0] = 5'd7;
        cycle("wb_bypass", 2'b01, 32'h0);

        // Set beats a same-cycle clear; writeback of a free register is ignored.
        idle(); inst_valid = 2'b01; r_reg[0][0] = 5'd1; w_reg[0] = 5'd9; long_lat = 2'b01;
        wb_valid = 2'b10; wb_reg[1] = 5'd9;
        cycle("set_wins", 2'b01, 32'h0000_0200);
        idle(); wb_valid = 2'b01; wb_reg[0] = 5'd12;
        cycle("wb_free", 2'b00, 32'h0000_0200);
        idle(); inst_valid = 2'b11; r_reg[0][0] = 5'd1; w_reg[0] = 5'd2; r_reg[1][0] = 5'd3; w_reg[1] = 5'd11;
        long_lat = 2'b10;
        cycle("slot1_long", 2'b11, 32'h0000_0A00);
        idle(); inst_valid = 2'b01; r_reg[0][0] = 5'd1; long_lat = 2'b01;
        cycle("long_r0", 2'b01, 32'h0000_0A00);
        idle(); wb_valid = 2'b10; wb_reg[1] = 5'd11;
        cycle("wb_port1", 2'b00, 32'h0000_0200);

        // Stall holds ex_valid; flush kills issue and ex_valid but keeps the scoreboard.
        idle(); indep_pair();
        cycle("pre_stall", 2'b11, 32'h0000_0200);
        idle(); indep_pair(); ex_ready = 1'b0;
        cycle("stall_hold", 2'b00, 32'h0000_0200);
        idle(); indep_pair(); flush = 1'b1;
        cycle("flush_mid", 2'b00, 32'h0000_0200);

        // Reset with a busy scoreboard clears everything.
        idle(); indep_pair(); rst_n = 1'b0;
        cycle("reset_busy", 2'b00, 32'h0);
        rst_n = 1'b1;
        idle(); indep_pair();
        cycle("post_reset", 2'b11, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
